mem_responder: RTL and testbench
================================

# mem_responder

Unified instruction/data memory responder for the multicycle CPU. It serves the memory requests the control unit issues: instruction fetch (iord=0) and lb/sb data accesses (iord=1). Requests are held until a one-cycle ready pulse, with a fixed number of wait states. Byte stores run as an internal read-modify-write over a word-organised RAM.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth 2^ADDR_WIDTH words of 32 bits
- WAIT_CYCLES, 2, wait states inserted before the RAM access (0 allowed)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- memread_i  input  1  read request; held until ready_o
- memwrite_i  input  1  write request; held until ready_o
- iord_i  input  1  0 = instruction word fetch, 1 = data byte access
- addr_i  input  32  byte address
- wdata_i  input  32  store data; only bits [7:0] are used
- rdata_o  output  32  read data, valid while ready_o=1
- ready_o  output  1  one-cycle completion pulse
- busy_o  output  1  high from acceptance through the DONE cycle
- err_o  output  1  pulses together with ready_o on an illegal request
- rd_cnt_o  output  16  completed-read counter (see Configuration)
- wr_cnt_o  output  16  completed-write counter (see Configuration)

## Operation
- States: IDLE, WAIT, ACCESS, MERGE, DONE.
- IDLE: a request is accepted when memread_i or memwrite_i is high. On acceptance, addr_i, wdata_i[7:0], iord_i and the op are latched. The request inputs are ignored after acceptance.
- IDLE transitions to WAIT with counter = WAIT_CYCLES. If WAIT_CYCLES=0, IDLE goes directly to ACCESS.
- WAIT: counter decrements each cycle. WAIT goes to ACCESS on the cycle the counter reaches 1.
- ACCESS: the RAM word at addr[ADDR_WIDTH+1:2] is read. A read goes to DONE; a byte store goes to MERGE.
- MERGE: the latched byte is written into its lane of the read word, and the word is written back. MERGE goes to DONE.
- DONE: ready_o=1 for one cycle, then IDLE. Requests present in DONE are not accepted.
- Byte lanes are big-endian: addr[1:0]=0 selects bits [31:24], 3 selects bits [7:0].
- lb returns the selected byte sign-extended to 32 bits. A fetch returns the full word.
- Illegal requests complete through DONE with err_o=1, rdata_o=0 and no RAM write:
  - memread_i and memwrite_i both high
  - fetch with addr[1:0]≠0
  - memwrite_i with iord_i=0
  - any addr bit above ADDR_WIDTH+1 set
- Illegal requests still spend the WAIT cycles, so latency is uniform.
- RAM contents are not cleared by reset.

## Timing
- Reset values: state IDLE, ready_o=0, busy_o=0, err_o=0, rdata_o=0, rd_cnt_o=0, wr_cnt_o=0.
- Acceptance edge T (IDLE, request high):
  - reads and errors: ready_o at cycle T+WAIT_CYCLES+2
  - byte stores: ready_o at cycle T+WAIT_CYCLES+3
- Minimum back-to-back spacing: a new request can be accepted in the cycle after DONE.
- busy_o rises the cycle after acceptance and falls after DONE.
- rdata_o holds its last value until the next DONE. It is defined only while ready_o=1.
- rst asserted in any state: next cycle is IDLE with no ready pulse. A store aborted before the MERGE edge leaves RAM unchanged.

## Configuration
- MEM_ACCESS_CNT_EN defined:
  - rd_cnt_o increments on each non-error read DONE.
  - wr_cnt_o increments on each non-error store DONE.
  - Both counters are 16-bit and wrap from 0xFFFF to 0.
  - Both are cleared by rst.
- MEM_ACCESS_CNT_EN undefined: counter logic is absent and rd_cnt_o, wr_cnt_o are tied to 0.

## Test plan
- Fetch, word 0x12345678 preloaded at 0x10, WAIT_CYCLES=2: request accepted at T -> ready_o at T+4, rdata_o=0x12345678, err_o=0.
- lb 0x13 on word 0x123456F0 -> rdata_o=0xFFFFFFF0. lb 0x10 on the same word -> rdata_o=0x00000012.
- sb addr 0x21, wdata_i=0x000000AB, word 0x11223344 preloaded -> ready_o at T+5. A following fetch of 0x20 returns 0x11AB3344.
- Illegal requests (fetch at 0x02; memread+memwrite together; memwrite with iord=0) -> ready_o with err_o=1, rdata_o=0, RAM unchanged, counters unchanged.
- rst asserted during the MERGE-bound WAIT of an sb to 0x30 -> no ready pulse, state IDLE next cycle, word at 0x30 unchanged.
- WAIT_CYCLES=0, MEM_ACCESS_CNT_EN defined: three fetches back-to-back, each ready two cycles after acceptance, then one sb -> rd_cnt_o=3, wr_cnt_o=1.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM that serves fetch and lb/sb requests with fixed wait states.
// Optional completed-access counters are enabled by defining MEM_ACCESS_CNT_EN.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        iord_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_MERGE,
    S_DONE
  } state_t;

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WINIT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] WONE  = CW'(1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [7:0] byte_q, byte_d;
  logic iord_q, iord_d;
  logic we_q, we_d;
  logic err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem_q [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0] lane;
  logic [31:0] rd_word;
  logic [7:0] sel_byte;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic req;
  logic req_err;
  logic mem_we;
  logic unused_wdata;

  assign unused_wdata = ^wdata_i[31:8];

  assign idx     = addr_q[ADDR_WIDTH+1:2];
  assign lane    = addr_q[1:0];
  assign rd_word = mem_q[idx];
  assign req     = memread_i | memwrite_i;

  // Legality is decided once, at acceptance, so later input changes cannot matter.
  assign req_err = (memread_i & memwrite_i)
                 | (~iord_i & (|addr_i[1:0]))
                 | (memwrite_i & ~iord_i)
                 | (|addr_i[31:ADDR_WIDTH+2]);

  always_comb begin
    sel_byte = 8'h00;
    merged   = word_q;
    unique case (lane)
      2'd0: begin
        sel_byte = rd_word[31:24];
        merged   = {byte_q, word_q[23:0]};
      end
      2'd1: begin
        sel_byte = rd_word[23:16];
        merged   = {word_q[31:24], byte_q, word_q[15:0]};
      end
      2'd2: begin
        sel_byte = rd_word[15:8];
        merged   = {word_q[31:16], byte_q, word_q[7:0]};
      end
      2'd3: begin
        sel_byte = rd_word[7:0];
        merged   = {word_q[31:8], byte_q};
      end
      default: ;
    endcase
  end

  assign load_val = iord_q ? {{24{sel_byte[7]}}, sel_byte}
                           : rd_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    byte_d  = byte_q;
    iord_d  = iord_q;
    we_d    = we_q;
    err_d   = err_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr_i[ADDR_WIDTH+1:0];
          byte_d  = wdata_i[7:0];
          iord_d  = iord_i;
          we_d    = memwrite_i;
          err_d   = req_err;
          cnt_d   = WINIT;
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - WONE;
        if (cnt_q == WONE) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        word_d = rd_word;
        if (we_q && !err_q) begin
          state_d = S_MERGE;
        end else begin
          rdata_d = err_q ? 32'h0 : load_val;
          state_d = S_DONE;
        end
      end
      S_MERGE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      iord_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      iord_q  <= iord_d;
      we_q    <= we_d;
      err_q   <= err_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is never cleared; a reset in MERGE suppresses the write-back.
  assign mem_we = (state_q == S_MERGE) && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merged;
  end

  assign ready_o = (state_q == S_DONE);
  assign busy_o  = (state_q != S_IDLE);
  assign err_o   = ready_o & err_q;
  assign rdata_o = rdata_q;

`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == S_DONE && !err_q) begin
      if (we_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`else
  assign rd_cnt_o = 16'h0;
  assign wr_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst;

  logic a_rd, a_wr, a_iord;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic a_ready, a_busy, a_err;
  logic [15:0] a_rdc, a_wrc;

  logic b_rd, b_wr, b_iord;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic b_ready, b_busy, b_err;
  logic [15:0] b_rdc, b_wrc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst),
    .memread_i(a_rd), .memwrite_i(a_wr), .iord_i(a_iord),
    .addr_i(a_addr), .wdata_i(a_wdata),
    .rdata_o(a_rdata), .ready_o(a_ready), .busy_o(a_busy),
    .err_o(a_err), .rd_cnt_o(a_rdc), .wr_cnt_o(a_wrc)
  );

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst),
    .memread_i(b_rd), .memwrite_i(b_wr), .iord_i(b_iord),
    .addr_i(b_addr), .wdata_i(b_wdata),
    .rdata_o(b_rdata), .ready_o(b_ready), .busy_o(b_busy),
    .err_o(b_err), .rd_cnt_o(b_rdc), .wr_cnt_o(b_wrc)
  );

  // Drives one request in an IDLE cycle T; lat counts edges until ready_o.
  task automatic req(input bit d, input logic rd, input logic wr,
                     input logic io, input logic [31:0] ad,
                     input logic [31:0] wd, output int lat,
                     output logic [31:0] data, output logic er);
    int n;
    bit got;
    @(posedge clk); #1;
    if (!d) begin
      a_rd = rd; a_wr = wr; a_iord = io; a_addr = ad; a_wdata = wd;
    end else begin
      b_rd = rd; b_wr = wr; b_iord = io; b_addr = ad; b_wdata = wd;
    end
    lat = 0; data = 32'h0; er = 1'b0; got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!d && a_ready) begin
        got = 1'b1; lat = n; data = a_rdata; er = a_err;
      end else if (d && b_ready) begin
        got = 1'b1; lat = n; data = b_rdata; er = b_err;
      end
    end
    a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout addr=%h: no ready_o within 20 cycles", ad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({a_ready, a_busy, a_err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=000", {a_ready, a_busy, a_err});
    end
    tests++;
    if (a_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata got=%h exp=0", a_rdata);
    end
    tests++;
    if ({b_rdc, b_wrc} !== 32'h0) begin
      fails++;
      $display("FAIL reset_cnt got=%h exp=0", {b_rdc, b_wrc});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int lat;
    logic [31:0] d;
    logic e;
    u_a.mem_q[4] = 32'h12345678;
    req(0, 1, 0, 0, 32'h10, 32'h0, lat, d, e);
    tests++;
    if (lat !== 4) begin
      fails++; $display("FAIL fetch_lat got=%0d exp=4", lat);
    end
    tests++;
    if (d !== 32'h12345678) begin
      fails++; $display("FAIL fetch_data got=%h exp=12345678", d);
    end
    tests++;
    if (e !== 1'b0) begin
      fails++; $display("FAIL fetch_err got=%b exp=0", e);
    end
  endtask

  task automatic test_lb();
    int lat;
    logic [31:0] d;
    logic e;
    u_a.mem_q[4] = 32'h123456F0;
    req(0, 1, 0, 1, 32'h13, 32'h0, lat, d, e);
    tests++;
    if (d !== 32'hFFFFFFF0 || lat !== 4) begin
      fails++; $display("FAIL lb_13 got=%h/%0d exp=fffffff0/4", d, lat);
    end
    req(0, 1, 0, 1, 32'h10, 32'h0, lat, d, e);
    tests++;
    if (d !== 32'h00000012) begin
      fails++; $display("FAIL lb_10 got=%h exp=00000012", d);
    end
  endtask

  task automatic test_sb();
    int lat;
    logic [31:0] d;
    logic e;
    u_a.mem_q[8] = 32'h11223344;
    req(0, 0, 1, 1, 32'h21, 32'h000000AB, lat, d, e);
    tests++;
    if (lat !== 5 || e !== 1'b0) begin
      fails++; $display("FAIL sb_lat got=%0d/%b exp=5/0", lat, e);
    end
    req(0, 1, 0, 0, 32'h20, 32'h0, lat, d, e);
    tests++;
    if (d !== 32'h11AB3344) begin
      fails++; $display("FAIL sb_merge got=%h exp=11ab3344", d);
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] d;
    logic e;
    logic [31:0] ad [4];
    logic [2:0] op [4];
    ad[0] = 32'h02;   op[0] = 3'b100;
    ad[1] = 32'h40;   op[1] = 3'b111;
    ad[2] = 32'h40;   op[2] = 3'b010;
    ad[3] = 32'h1000; op[3] = 3'b101;
    u_a.mem_q[16] = 32'hA1B2C3D4;
    for (int i = 0; i < 4; i++) begin
      req(0, op[i][2], op[i][1], op[i][0], ad[i], 32'h55, lat, d, e);
      tests++;
      if (e !== 1'b1 || d !== 32'h0 || lat !== 4) begin
        fails++;
        $display("FAIL illegal_%0d got err=%b data=%h lat=%0d exp 1/0/4",
                 i, e, d, lat);
      end
    end
    req(0, 1, 0, 0, 32'h40, 32'h0, lat, d, e);
    tests++;
    if (d !== 32'hA1B2C3D4 || e !== 1'b0) begin
      fails++; $display("FAIL illegal_ram got=%h exp=a1b2c3d4", d);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    logic [31:0] d;
    logic e;
    u_a.mem_q[12] = 32'hCAFEBABE;
    @(posedge clk); #1;
    a_wr = 1; a_iord = 1; a_addr = 32'h30; a_wdata = 32'h77;
    @(posedge clk); #1;
    a_wr = 0;
    tests++;
    if (a_busy !== 1'b1) begin
      fails++; $display("FAIL abort_busy got=%b exp=1", a_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle got busy=%b ready=%b exp 0/0", a_busy, a_ready);
    end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (a_ready) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL abort_ready got=%0d exp=0", seen);
    end
    req(0, 1, 0, 0, 32'h30, 32'h0, lat, d, e);
    tests++;
    if (d !== 32'hCAFEBABE) begin
      fails++; $display("FAIL abort_ram got=%h exp=cafebabe", d);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] d;
    logic e;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    logic [31:0] w [4];
    w[0] = 32'h0A0B0C0D; w[1] = 32'h89ABCDEF;
    w[2] = 32'h00FF00FF; w[3] = 32'h01020304;
    for (int i = 0; i < 4; i++) u_b.mem_q[i] = w[i];
`ifdef MEM_ACCESS_CNT_EN
    exp_rd = 16'd3; exp_wr = 16'd1;
`else
    exp_rd = 16'd0; exp_wr = 16'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      req(1, 1, 0, 0, 32'(i * 4), 32'h0, lat, d, e);
      tests++;
      if (lat !== 2 || d !== w[i] || e !== 1'b0) begin
        fails++;
        $display("FAIL b2b_fetch_%0d got=%h/%0d exp=%h/2", i, d, lat, w[i]);
      end
    end
    req(1, 0, 1, 1, 32'h0D, 32'h5A, lat, d, e);
    tests++;
    if (lat !== 3) begin
      fails++; $display("FAIL b2b_sb_lat got=%0d exp=3", lat);
    end
    @(posedge clk); #1;
    tests++;
    if (b_rdc !== exp_rd || b_wrc !== exp_wr) begin
      fails++;
      $display("FAIL b2b_cnt got=%0d/%0d exp=%0d/%0d",
               b_rdc, b_wrc, exp_rd, exp_wr);
    end
    req(1, 1, 0, 0, 32'h01, 32'h0, lat, d, e);
    tests++;
    if (e !== 1'b1 || lat !== 2) begin
      fails++; $display("FAIL b2b_err got=%b/%0d exp=1/2", e, lat);
    end
    @(posedge clk); #1;
    tests++;
    if (b_rdc !== exp_rd || b_wrc !== exp_wr) begin
      fails++;
      $display("FAIL b2b_cnt_err got=%0d/%0d exp=%0d/%0d",
               b_rdc, b_wrc, exp_rd, exp_wr);
    end
    req(1, 1, 0, 0, 32'h0C, 32'h0, lat, d, e);
    tests++;
    if (d !== 32'h015A0304) begin
      fails++; $display("FAIL b2b_merge got=%h exp=015a0304", d);
    end
  endtask

  initial begin
    a_rd = 0; a_wr = 0; a_iord = 0; a_addr = 0; a_wdata = 0;
    b_rd = 0; b_wr = 0; b_iord = 0; b_addr = 0; b_wdata = 0;
    rst = 1'b1;
    test_reset();
    test_fetch();
    test_lb();
    test_sb();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
